aes_out_fifo: RTL and testbench

//  Downstream stage of the AES wrapper. The wrapper's ovalid/oid/odata result port has no back-pressure, so this block captures it.
//  It buffers each 128-bit result with its 32-bit id in a FIFO of DEPTH entries.
//  It replays each result as a 4-beat, 32-bit AXI-stream packet (tlast on beat 3) to the host-side interface.

---
 rtl/aes_out_fifo.sv | 76 +++++++
 tb/tb_aes_out_fifo.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/aes_out_fifo.sv
// aes_out_fifo: buffers AES results {id, 128-bit data} and replays each as a
// 4-beat 32-bit AXI-stream packet, MSB word first; drops and flags on overflow.
module aes_out_fifo #(
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic          sclk,
    input  logic          srst_n,
    input  logic          ivalid,
    input  logic [31:0]   iid,
    input  logic [127:0]  idata,
    output logic          iready,
    output logic          m_tvalid,
    input  logic          m_tready,
    output logic [31:0]   m_tdata,
    output logic [31:0]   m_tid,
    output logic          m_tlast,
    output logic [AW:0]   level,
    output logic          overflow,
    input  logic          clr_overflow
);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [159:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic [1:0]    beat_q, beat_d;
    logic          overflow_q, overflow_d;
    logic          full, empty, push, pop, drop, beat_fire;
    logic [159:0]  head;

    always_comb begin
        full      = count_q == FULL_CNT;
        empty     = count_q == '0;
        m_tvalid  = !empty;
        beat_fire = m_tvalid & m_tready;
        pop       = beat_fire & (beat_q == 2'd3);
        push      = ivalid & (!full | pop);
        drop      = ivalid & full & !pop;
        wr_ptr_d  = wr_ptr_q + AW'(push);
        rd_ptr_d  = rd_ptr_q + AW'(pop);
        count_d   = count_q + (AW + 1)'(push) - (AW + 1)'(pop);
        beat_d    = beat_q + {1'b0, beat_fire};
        // a drop in the same cycle as a clear keeps the flag set
        overflow_d = drop ? 1'b1 : (clr_overflow ? 1'b0 : overflow_q);
        head      = mem_q[rd_ptr_q];
        m_tid     = head[159:128];
        m_tdata   = beat_q == 2'd0 ? head[127:96] :
                    beat_q == 2'd1 ? head[95:64]  :
                    beat_q == 2'd2 ? head[63:32]  : head[31:0];
        m_tlast   = m_tvalid & (beat_q == 2'd3);
        iready    = !full;
        level     = count_q;
        overflow  = overflow_q;
    end

    always_ff @(posedge sclk or negedge srst_n) begin
        if (!srst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            beat_q     <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            beat_q     <= beat_d;
            overflow_q <= overflow_d;
        end
    end

    always_ff @(posedge sclk) begin
        if (push) mem_q[wr_ptr_q] <= {iid, idata};
    end
endmodule

// File: tb/tb_aes_out_fifo.sv
// tb_aes_out_fifo: directed checks of aes_out_fifo with hand-computed expectations.
module tb_aes_out_fifo;
    logic         sclk, srst_n, ivalid, iready, m_tvalid, m_tready, m_tlast;
    logic         overflow, clr_overflow;
    logic [31:0]  iid, m_tdata, m_tid;
    logic [127:0] idata;
    logic [2:0]   level;
    int           checks, failures;
    logic [31:0]  w3 [4];

    aes_out_fifo #(.DEPTH(4)) dut (
        .sclk(sclk), .srst_n(srst_n), .ivalid(ivalid), .iid(iid), .idata(idata),
        .iready(iready), .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tdata(m_tdata),
        .m_tid(m_tid), .m_tlast(m_tlast), .level(level), .overflow(overflow),
        .clr_overflow(clr_overflow)
    );

    initial sclk = 1'b0;
    always #5 sclk = ~sclk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge sclk);
        #1;
    endtask

    initial begin
        checks = 0; failures = 0;
        srst_n = 1'b0; ivalid = 1'b0; iid = '0; idata = '0;
        m_tready = 1'b1; clr_overflow = 1'b0;
        #12;
        chk("rst_tvalid", 128'(m_tvalid), 128'd0);
        chk("rst_tlast", 128'(m_tlast), 128'd0);
        chk("rst_level", 128'(level), 128'd0);
        chk("rst_iready", 128'(iready), 128'd1);
        chk("rst_overflow", 128'(overflow), 128'd0);
        step();
        srst_n = 1'b1;
        step();

        // T2: single entry, m_tready held high
        ivalid = 1'b1; iid = 32'h5; idata = 128'h00112233_44556677_8899AABB_CCDDEEFF;
        step();
        ivalid = 1'b0;
        chk("t2_b0_valid", 128'(m_tvalid), 128'd1);
        chk("t2_b0_data", 128'(m_tdata), 128'h00112233);
        chk("t2_b0_tid", 128'(m_tid), 128'h5);
        chk("t2_b0_last", 128'(m_tlast), 128'd0);
        chk("t2_level", 128'(level), 128'd1);
        step();
        chk("t2_b1_data", 128'(m_tdata), 128'h44556677);
        chk("t2_b1_last", 128'(m_tlast), 128'd0);
        step();
        chk("t2_b2_data", 128'(m_tdata), 128'h8899AABB);
        chk("t2_b2_tid", 128'(m_tid), 128'h5);
        step();
        chk("t2_b3_data", 128'(m_tdata), 128'hCCDDEEFF);
        chk("t2_b3_last", 128'(m_tlast), 128'd1);
        chk("t2_b3_tid", 128'(m_tid), 128'h5);
        step();
        chk("t2_done_valid", 128'(m_tvalid), 128'd0);
        chk("t2_done_level", 128'(level), 128'd0);

        // T3: m_tready alternating 0/1, every beat held while stalled
        w3[0] = 32'hA0A1A2A3; w3[1] = 32'hB0B1B2B3; w3[2] = 32'hC0C1C2C3; w3[3] = 32'hD0D1D2D3;
        ivalid = 1'b1; iid = 32'h7; idata = {w3[0], w3[1], w3[2], w3[3]};
        step();
        ivalid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            m_tready = 1'b0;
            chk("t3_data", 128'(m_tdata), 128'(w3[k]));
            step();
            chk("t3_stall_data", 128'(m_tdata), 128'(w3[k]));
            chk("t3_stall_tid", 128'(m_tid), 128'h7);
            chk("t3_stall_last", 128'(m_tlast), 128'(k == 3));
            m_tready = 1'b1;
            step();
        end
        chk("t3_done_valid", 128'(m_tvalid), 128'd0);

        // T1: reset mid-packet
        ivalid = 1'b1; iid = 32'h9; idata = 128'h1;
        step();
        ivalid = 1'b0;
        step();
        chk("t1_mid_valid", 128'(m_tvalid), 128'd1);
        srst_n = 1'b0;
        #1;
        chk("t1_async_valid", 128'(m_tvalid), 128'd0);
        chk("t1_async_level", 128'(level), 128'd0);
        chk("t1_async_iready", 128'(iready), 128'd1);
        step();
        srst_n = 1'b1;
        step();
        step();
        chk("t1_no_stale", 128'(m_tvalid), 128'd0);

        // T4: fill with m_tready low, drop on the fifth push, clear
        m_tready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            ivalid = 1'b1; iid = 32'h10 + 32'(i); idata = {4{32'h10000010 + 32'(i)}};
            step();
        end
        ivalid = 1'b0;
        chk("t4_level_full", 128'(level), 128'd4);
        chk("t4_iready_full", 128'(iready), 128'd0);
        chk("t4_ovf_before", 128'(overflow), 128'd0);
        ivalid = 1'b1; iid = 32'h99; idata = '1;
        step();
        ivalid = 1'b0;
        chk("t4_ovf_set", 128'(overflow), 128'd1);
        chk("t4_level_drop", 128'(level), 128'd4);
        chk("t4_head_kept", 128'(m_tid), 128'h10);
        clr_overflow = 1'b1;
        step();
        clr_overflow = 1'b0;
        chk("t4_ovf_clr", 128'(overflow), 128'd0);
        clr_overflow = 1'b1; ivalid = 1'b1;
        step();
        clr_overflow = 1'b0; ivalid = 1'b0;
        chk("t4_set_wins", 128'(overflow), 128'd1);
        clr_overflow = 1'b1;
        step();
        clr_overflow = 1'b0;
        chk("t4_ovf_clr2", 128'(overflow), 128'd0);

        // T5: full FIFO, push on the pop cycle is accepted
        m_tready = 1'b1;
        step(); step(); step();
        chk("t5_b3_last", 128'(m_tlast), 128'd1);
        chk("t5_b3_data", 128'(m_tdata), 128'h10000010);
        chk("t5_iready_full", 128'(iready), 128'd0);
        ivalid = 1'b1; iid = 32'h20; idata = 128'hFEEDFACE_0BADF00D_DEADBEEF_12345678;
        step();
        ivalid = 1'b0;
        chk("t5_level", 128'(level), 128'd4);
        chk("t5_ovf", 128'(overflow), 128'd0);
        chk("t5_next_tid", 128'(m_tid), 128'h11);
        chk("t5_next_data", 128'(m_tdata), 128'h10000011);
        chk("t5_next_last", 128'(m_tlast), 128'd0);
        for (int i = 0; i < 12; i++) step();
        chk("t5_new_tid", 128'(m_tid), 128'h20);
        chk("t5_new_data", 128'(m_tdata), 128'hFEEDFACE);
        chk("t5_new_level", 128'(level), 128'd1);
        for (int i = 0; i < 4; i++) step();
        chk("t5_drained", 128'(level), 128'd0);

        // T6: ids 1..8 streamed back to back
        ivalid = 1'b1; iid = 32'd1;
        idata = {32'h101, 32'h201, 32'h301, 32'h401};
        step();
        ivalid = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            for (int b = 0; b < 4; b++) begin
                chk("t6_valid", 128'(m_tvalid), 128'd1);
                chk("t6_tid", 128'(m_tid), 128'(i));
                chk("t6_data", 128'(m_tdata), 128'(32'(i) + 32'((b + 1) * 256)));
                chk("t6_level", 128'(level), 128'd1);
                if (b == 3 && i < 8) begin
                    ivalid = 1'b1; iid = 32'(i + 1);
                    idata = {32'h100 + 32'(i + 1), 32'h200 + 32'(i + 1),
                             32'h300 + 32'(i + 1), 32'h400 + 32'(i + 1)};
                end
                step();
                ivalid = 1'b0;
            end
        end
        chk("t6_end_valid", 128'(m_tvalid), 128'd0);
        chk("t6_end_level", 128'(level), 128'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
